// File: rtl/instruction_loader.sv
// Byte-stream program loader: receives a word count, 4*N little-endian data bytes and an
// XOR checksum, writes each assembled word into instruction memory, and holds the core in
// reset until the load has finished.
module instruction_loader #(
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  im_write_enable,
    output logic [ADDR_WIDTH-1:0] im_write_address,
    output logic [31:0]           im_write_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    // Widened by one bit so MEM_DEPTH = 65536 would still compare correctly.
    localparam logic [16:0] MaxWords = 17'(MEM_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StCountLo,
        StCountHi,
        StData,
        StWrite,
        StCheck,
        StDone,
        StError
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           word_q, word_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [15:0]           count_q, count_d;
    logic [7:0]            csum_q, csum_d;
    logic [15:0]           count_full;
    logic                  begin_session;

    // Next-state, datapath updates and state-decoded outputs.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        word_d          = word_q;
        byte_cnt_d      = byte_cnt_q;
        count_d         = count_q;
        csum_d          = csum_q;
        rx_ready        = 1'b0;
        im_write_enable = 1'b0;
        cpu_hold        = 1'b0;
        done            = 1'b0;
        error           = 1'b0;
        begin_session   = 1'b0;
        count_full      = {rx_data, count_q[7:0]};

        unique case (state_q)
            StIdle: begin
                begin_session = start;
            end
            StCountLo: begin
                rx_ready = 1'b1;
                cpu_hold = 1'b1;
                if (rx_valid) begin
                    count_d = {8'h00, rx_data};
                    state_d = StCountHi;
                end
            end
            StCountHi: begin
                rx_ready = 1'b1;
                cpu_hold = 1'b1;
                if (rx_valid) begin
                    count_d = count_full;
                    if (count_full == 16'd0 || {1'b0, count_full} > MaxWords) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                rx_ready = 1'b1;
                cpu_hold = 1'b1;
                if (rx_valid) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
                    csum_d     = csum_q ^ rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                im_write_enable = 1'b1;
                cpu_hold        = 1'b1;
                addr_d          = addr_q + 1'b1;
                count_d         = count_q - 16'd1;
                state_d         = (count_q == 16'd1) ? StCheck : StData;
            end
            StCheck: begin
                rx_ready = 1'b1;
                cpu_hold = 1'b1;
                if (rx_valid) begin
                    state_d = (rx_data == csum_q) ? StDone : StError;
                end
            end
            StDone: begin
                done          = 1'b1;
                begin_session = start;
            end
            StError: begin
                error         = 1'b1;
                cpu_hold      = 1'b1;
                begin_session = start;
            end
            default: state_d = StIdle;
        endcase

        if (begin_session) begin
            state_d    = StCountLo;
            addr_d     = '0;
            word_d     = '0;
            byte_cnt_d = '0;
            count_d    = '0;
            csum_d     = '0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            word_q     <= '0;
            byte_cnt_q <= '0;
            count_q    <= '0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            count_q    <= count_d;
            csum_q     <= csum_d;
        end
    end

    assign im_write_address = addr_q;
    assign im_write_data    = word_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: stimulus pushes expected writes, a monitor pops
// and compares them whenever the loader strobes im_write_enable.
module tb_instruction_loader;

    localparam int unsigned MEM_DEPTH  = 1024;
    localparam int unsigned ADDR_WIDTH = 10;

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  im_write_enable;
    logic [ADDR_WIDTH-1:0] im_write_address;
    logic [31:0]           im_write_data;
    logic                  cpu_hold;
    logic                  done;
    logic                  error;

    int checks = 0;
    int errors = 0;
    int write_count = 0;

    logic [ADDR_WIDTH-1:0] exp_addr_q[$];
    logic [31:0]           exp_data_q[$];
    logic [7:0]            stim_q[$];
    int                    waits_q[$];

    instruction_loader #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .im_write_enable (im_write_enable),
        .im_write_address(im_write_address),
        .im_write_data   (im_write_data),
        .cpu_hold        (cpu_hold),
        .done            (done),
        .error           (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (reset && im_write_enable) begin
            write_count++;
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected none",
                         im_write_address, im_write_data);
            end else begin
                logic [ADDR_WIDTH-1:0] ea;
                logic [31:0]           ed;
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                if (im_write_address !== ea || im_write_data !== ed) begin
                    errors++;
                    $display("FAIL write: got addr %h data %h expected addr %h data %h",
                             im_write_address, im_write_data, ea, ed);
                end
            end
        end
    end

    task automatic expect_write(input logic [ADDR_WIDTH-1:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    // Called at a negedge; returns at the negedge after start was sampled.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; leaves rx_valid high with the byte already accepted.
    task automatic send_byte(input logic [7:0] b, output int waits);
        waits = 0;
        while (!rx_ready && waits < 20) begin
            rx_valid = 1'b0;
            @(negedge clk);
            waits++;
        end
        if (waits >= 20) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout: got rx_ready 0 expected 1 within 20 cycles");
        end
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_stream(input int gap);
        int w;
        waits_q.delete();
        foreach (stim_q[i]) begin
            send_byte(stim_q[i], w);
            waits_q.push_back(w);
            if (gap > 0) begin
                rx_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {rx_ready, im_write_enable, cpu_hold, done, error,
                     22'(im_write_address)}, 32'h0);
        check({name, "_data"}, im_write_data, 32'h0);
    endtask

    initial begin
        int wc;
        reset    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        reset = 1'b1;
        @(negedge clk);

        // Single word, good checksum.
        expect_write(10'd0, 32'h2BC00513);
        pulse_start();
        check("cpu_hold_loading", cpu_hold, 1'b1);
        stim_q = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hC0, 8'h2B, 8'hFD};
        send_stream(0);
        check("single_done", {done, error, cpu_hold, rx_ready}, 4'b1000);

        // Two words back-to-back; one stall cycle after each fourth byte.
        expect_write(10'd0, 32'h44332211);
        expect_write(10'd1, 32'h88776655);
        pulse_start();
        stim_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                   8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
        send_stream(0);
        check("b2b_no_wait", waits_q[3], 32'd0);
        check("b2b_wait_word0", waits_q[6], 32'd1);
        check("b2b_wait_word1", waits_q[10], 32'd1);
        check("b2b_done", {done, error}, 2'b10);

        // Zero count and oversize count abort without writing.
        wc = write_count;
        pulse_start();
        stim_q = '{8'h00, 8'h00};
        send_stream(0);
        check("zero_error", {done, error, cpu_hold, rx_ready}, 4'b0110);
        pulse_start();
        stim_q = '{8'h01, 8'h04};
        send_stream(0);
        check("oversize_error", {done, error, cpu_hold}, 3'b011);
        check("abort_no_write", write_count, wc);

        // Bad checksum: the word is still written, then error.
        expect_write(10'd0, 32'h2BC00513);
        pulse_start();
        check("start_clears_error", error, 1'b0);
        stim_q = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hC0, 8'h2B, 8'h00};
        send_stream(0);
        check("bad_csum", {done, error, cpu_hold}, 3'b011);

        // Reset mid-word discards the partial word.
        wc = write_count;
        pulse_start();
        stim_q = '{8'h01, 8'h00, 8'h13, 8'h05};
        send_stream(0);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midreset_outputs");
        reset = 1'b1;
        @(negedge clk);
        check("midreset_no_write", write_count, wc);
        expect_write(10'd0, 32'h2BC00513);
        pulse_start();
        stim_q = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hC0, 8'h2B, 8'hFD};
        send_stream(0);
        check("after_reset_done", {done, error, cpu_hold}, 3'b100);

        // start inside DATA is ignored; rx_valid gaps only stall.
        expect_write(10'd0, 32'h2BC00513);
        pulse_start();
        stim_q = '{8'h01, 8'h00, 8'h13, 8'h05};
        send_stream(0);
        pulse_start();
        check("start_ignored_hold", cpu_hold, 1'b1);
        stim_q = '{8'hC0, 8'h2B, 8'hFD};
        send_stream(2);
        check("start_ignored_done", {done, error}, 2'b10);

        repeat (3) @(negedge clk);
        check("pending_writes", exp_addr_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
